// File: rtl/mem_port_ctrl.sv
// Word-granular RAM initiator for CPU byte/half/word loads and stores.
// Sub-word stores use read-modify-write; loads return lane-extracted, extended data.
module mem_port_ctrl #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              mem_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] RD_ADDR   = 4'd1;
  localparam logic [3:0] RD_CAP    = 4'd2;
  localparam logic [3:0] RD_DONE   = 4'd3;
  localparam logic [3:0] WR_WORD   = 4'd4;
  localparam logic [3:0] RMW_ADDR  = 4'd5;
  localparam logic [3:0] RMW_MERGE = 4'd6;
  localparam logic [3:0] RMW_WR    = 4'd7;
  localparam logic [3:0] ERR       = 4'd8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [3:0]        state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       mem_rdata_d, ram_din_d;
  logic              mem_ready_d, mem_err_d, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_d;

  logic        req_err_c;
  logic [4:0]  byte_sh_c, half_sh_c;
  logic [7:0]  byte_v_c;
  logic [15:0] half_v_c;
  logic [31:0] load_v_c, lane_mask_c, merged_c;

  // Request legality: size, natural alignment and address range
  assign req_err_c = (mem_size == 2'b11)
                  || ((mem_size == SZ_HALF) && mem_addr[0])
                  || ((mem_size == SZ_WORD) && (mem_addr[1:0] != 2'b00))
                  || ((mem_addr >> (ADDR_W + 2)) != 32'd0);

  assign byte_sh_c = {off_q, 3'b000};
  assign half_sh_c = {off_q[1], 4'b0000};
  assign byte_v_c  = ram_dout[byte_sh_c +: 8];
  assign half_v_c  = ram_dout[half_sh_c +: 16];

  // Lane extraction and extension for loads
  always_comb begin
    load_v_c    = ram_dout;
    lane_mask_c = 32'hFFFF_FFFF;
    case (size_q)
      SZ_BYTE: begin
        load_v_c    = mem_unsigned_ext8(byte_v_c, uns_q);
        lane_mask_c = 32'h0000_00FF << byte_sh_c;
      end
      SZ_HALF: begin
        load_v_c    = uns_q ? {16'd0, half_v_c} : {{16{half_v_c[15]}}, half_v_c};
        lane_mask_c = 32'h0000_FFFF << half_sh_c;
      end
      default: ;
    endcase
  end

  assign merged_c = (ram_dout & ~lane_mask_c) | ((wdata_q << byte_sh_c) & lane_mask_c);

  function automatic logic [31:0] mem_unsigned_ext8(input logic [7:0] b, input logic uns);
    return uns ? {24'd0, b} : {{24{b[7]}}, b};
  endfunction

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    mem_rdata_d = mem_rdata;
    ram_addr_d  = ram_addr;
    ram_din_d   = ram_din;
    mem_ready_d = 1'b0;
    mem_err_d   = 1'b0;
    ram_we_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          size_d  = mem_size;
          uns_d   = mem_unsigned;
          off_d   = mem_addr[1:0];
          wdata_d = mem_wdata;
          if (req_err_c) begin
            state_d     = ERR;
            mem_ready_d = 1'b1;
            mem_err_d   = 1'b1;
          end else begin
            ram_addr_d = mem_addr[ADDR_W+1:2];
            if (!mem_we) begin
              state_d = RD_ADDR;
            end else if (mem_size == SZ_WORD) begin
              state_d     = WR_WORD;
              ram_we_d    = 1'b1;
              ram_din_d   = mem_wdata;
              mem_ready_d = 1'b1;
            end else begin
              state_d = RMW_ADDR;
            end
          end
        end
      end
      RD_ADDR:  state_d = RD_CAP;
      RD_CAP: begin
        state_d     = RD_DONE;
        mem_rdata_d = load_v_c;
        mem_ready_d = 1'b1;
      end
      RMW_ADDR: state_d = RMW_MERGE;
      RMW_MERGE: begin
        state_d     = RMW_WR;
        ram_din_d   = merged_c;
        ram_we_d    = 1'b1;
        mem_ready_d = 1'b1;
      end
      RD_DONE, WR_WORD, RMW_WR, ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      off_q     <= 2'b00;
      wdata_q   <= 32'd0;
      mem_rdata <= 32'd0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= 32'd0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      mem_rdata <= mem_rdata_d;
      mem_ready <= mem_ready_d;
      mem_err   <= mem_err_d;
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_din   <= ram_din_d;
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Scoreboard bench for mem_port_ctrl: byte-array reference model, behavioural RAM,
// directed cases followed by randomized traffic.
module tb_mem_port_ctrl;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned NBYTES = 4 << ADDR_W;

  logic              clk, rst;
  logic              mem_req, mem_we, mem_unsigned;
  logic [1:0]        mem_size;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic              mem_ready, mem_err, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din, ram_dout;

  mem_port_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM, one-cycle read latency, read-before-write
  logic [31:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]       rdata;
    logic              err;
    logic              wr;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wword;
    int                lat;
    int                cyc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mb [0:NBYTES-1];
  logic [31:0] last_rdata;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: memory as a flat byte array, requests judged by byte arithmetic
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
    int n, a, base;
    logic [31:0] v;
    e = '{default: '0};
    n = 1 << size;
    a = int'(addr & 32'h0000_FFFF);
    if (size == 2'b11 || (addr % n) != 0 || addr >= NBYTES) begin
      e.err = 1'b1;
      e.rdata = last_rdata;
      e.lat = 1;
    end else if (!we) begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[a+i];
      if (!uns && n < 4 && v[8*n-1])
        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      last_rdata = v;
      e.rdata = v;
      e.lat = 3;
    end else begin
      for (int i = 0; i < n; i++) mb[a+i] = wdata[8*i +: 8];
      base = a - (a % 4);
      e.wr = 1'b1;
      e.waddr = ADDR_W'(base / 4);
      for (int i = 0; i < 4; i++) e.wword[8*i +: 8] = mb[base+i];
      e.rdata = last_rdata;
      e.lat = (n == 4) ? 1 : 3;
    end
  endtask

  // Monitor: pops an expectation on every completion pulse
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) begin
        if (sb.size() == 0) begin
          chk("ram_we_unexpected", 32'(ram_we), 32'd0);
        end else begin
          chk("ram_we_allowed", 32'(sb[0].wr), 32'd1);
          chk("ram_we_with_ready", 32'(mem_ready), 32'd1);
          chk("ram_addr", 32'(ram_addr), 32'(sb[0].waddr));
          chk("ram_din", ram_din, sb[0].wword);
        end
      end
      if (mem_ready) begin
        if (sb.size() == 0) begin
          chk("ready_unexpected", 32'(mem_ready), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("ready_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("mem_err", 32'(mem_err), 32'(mon_e.err));
          chk("mem_rdata", mem_rdata, mon_e.rdata);
          chk("ram_we_at_ready", 32'(ram_we), 32'(mon_e.wr));
        end
      end else if (mem_err) begin
        chk("err_without_ready", 32'(mem_err), 32'd0);
      end
    end
  end

  task automatic scramble();
    mem_we       = 1'($urandom);
    mem_size     = 2'($urandom);
    mem_unsigned = 1'($urandom);
    mem_addr     = $urandom;
    mem_wdata    = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 12) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Called just after a rising edge with the controller idle
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
    exp_t e;
    model(we, size, uns, addr, wdata, e);
    e.cyc = cyc + e.lat;
    mem_req = 1'b1; mem_we = we; mem_size = size; mem_unsigned = uns;
    mem_addr = addr; mem_wdata = wdata;
    sb.push_back(e);
    @(posedge clk); #1;
    mem_req = hold;
    scramble();
    drain();
    #1;
    if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, r;
    logic [1:0]  s;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'd0;
    for (int i = 0; i < int'(NBYTES); i++) mb[i] = 8'd0;
    last_rdata = 32'd0;
    rst = 1'b1; mem_req = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", ram_din, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word store/load, byte RMW, extension cases
    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0);
    issue(1, 2'b10, 0, 32'h10, 32'h11223344, 0);
    issue(1, 2'b00, 0, 32'h13, 32'h0000005A, 0);
    issue(0, 2'b00, 1, 32'h13, 32'h0, 0);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0);
    issue(1, 2'b10, 0, 32'h20, 32'h80000080, 0);
    issue(0, 2'b00, 0, 32'h20, 32'h0, 0);
    issue(0, 2'b00, 1, 32'h20, 32'h0, 0);
    issue(0, 2'b01, 0, 32'h22, 32'h0, 0);
    issue(0, 2'b01, 1, 32'h22, 32'h0, 0);

    // Illegal requests
    issue(0, 2'b10, 0, 32'h06, 32'h0, 0);
    issue(1, 2'b01, 0, 32'h01, 32'hFFFF, 0);
    issue(0, 2'b11, 0, 32'h10, 32'h0, 0);
    issue(0, 2'b10, 0, 32'h2000, 32'h0, 0);

    // Reset during RMW_MERGE of a byte store
    issue(1, 2'b10, 0, 32'h10, 32'h11223344, 0);
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b00; mem_unsigned = 1'b0;
    mem_addr = 32'h10; mem_wdata = 32'hFF;
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_ram_we", 32'(ram_we), 32'd0);
    chk("midrst_mem_ready", 32'(mem_ready), 32'd0);
    chk("midrst_mem_rdata", mem_rdata, 32'd0);
    chk("midrst_ram_addr", 32'(ram_addr), 32'd0);
    chk("midrst_ram_din", ram_din, 32'd0);
    last_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0);

    // Request held high across back-to-back loads
    for (int i = 0; i < 4; i++) issue(1, 2'b10, 0, 32'(4*i), $urandom, 0);
    for (int i = 0; i < 4; i++) issue(0, 2'b10, 0, 32'(4*i), 32'h0, 1);
    mem_req = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic over a small window plus occasional out-of-range addresses
    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 9);
      s = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0 && s != 2'b11) a = a & ~((32'd1 << s) - 32'd1);
      if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(13, 31));
      issue(1'($urandom), s, 1'($urandom), a, $urandom, ($urandom_range(0, 3) == 0));
    end
    mem_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
